// File: rtl/seqdet_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// seqdet_rr_scheduler_if
//   Groups the requester and hit signals of seqdet_rr_scheduler.
//
//   Parameter
//     NUM_CH     number of requester channels
//
//   Signals
//     req_valid  [NUM_CH]    per-channel symbol valid (source -> scheduler)
//     req_data   [3*NUM_CH]  per-channel symbol, channel c in [3c+2:3c]
//     req_ready  [NUM_CH]    one-hot grant (scheduler -> source)
//     hit_valid              one-cycle pulse per completed match
//     hit_ch     [3]         channel of the completed match
//
//   Handshake: a symbol moves from channel c when req_valid[c] and
//   req_ready[c] are both high at a rising clk edge. A source holds
//   req_valid/req_data stable until it sees the transfer; req_ready
//   depends combinationally on req_valid and never on anything later.
//
//   Modports
//     master     symbol source / hit consumer side
//     slave      scheduler side
// ---------------------------------------------------------------------------
interface seqdet_rr_scheduler_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]   req_valid;
    logic [3*NUM_CH-1:0] req_data;
    logic [NUM_CH-1:0]   req_ready;
    logic                hit_valid;
    logic [2:0]          hit_ch;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  hit_valid,
        input  hit_ch
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output hit_valid,
        output hit_ch
    );
endinterface

// File: rtl/seqdet_rr_scheduler.sv
// ---------------------------------------------------------------------------
// seqdet_rr_scheduler
//   One programmable 3-bit symbol-sequence matcher time-shared between
//   NUM_CH requester streams. A round-robin arbiter grants one symbol per
//   cycle; each channel keeps its own match progress so interleaved
//   streams are matched independently. Every completed match is reported
//   as a registered one-cycle pulse with the channel number.
//
//   Parameters
//     NUM_CH   number of requester channels (2..8)
//     MAX_LEN  maximum pattern length in symbols (2..8)
//
//   Ports
//     clk         clock
//     reset_n     asynchronous active-low reset
//     enable      1 = run matching, 0 = stop and allow configuration
//     cfg_sym_we  write cfg_sym into pattern slot cfg_addr (IDLE only)
//     cfg_addr    pattern slot index, values >= MAX_LEN ignored
//     cfg_sym     pattern symbol
//     cfg_len_we  write pattern length (IDLE only), clamped to MAX_LEN
//     cfg_len     pattern length in symbols
//     bus         requester / hit bundle (seqdet_rr_scheduler_if.slave)
//     busy        1 while the FSM is in RUN
//     dbg_state   current FSM state encoding (IDLE=0, CLEAR=1, RUN=2)
//
//   Optional build macro SEQDET_RR_HITCNT_EN adds per-channel 8-bit
//   saturating hit counters and the ports
//     cnt_sel     counter select
//     cnt_value   selected counter, 0 when cnt_sel >= NUM_CH
// ---------------------------------------------------------------------------
module seqdet_rr_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int MAX_LEN = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      cfg_sym_we,
    input  logic [2:0]                cfg_addr,
    input  logic [2:0]                cfg_sym,
    input  logic                      cfg_len_we,
    input  logic [3:0]                cfg_len,
    seqdet_rr_scheduler_if.slave      bus,
    output logic                      busy,
    output logic [1:0]                dbg_state
`ifdef SEQDET_RR_HITCNT_EN
    ,
    input  logic [2:0]                cnt_sel,
    output logic [7:0]                cnt_value
`endif
);

    localparam int         CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);
    localparam logic [2:0] LAST_CH   = 3'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    // Pattern store is always 8 deep so any 3-bit progress value indexes a
    // real entry; slots at or above MAX_LEN are never written and stay 0.
    logic [2:0]  pat_q  [8];
    logic [3:0]  len_q;
    logic [3:0]  prog_q [NUM_CH];
    logic [2:0]  ptr_q;

    // Arbitration results
    logic              grant_any;
    logic [2:0]        gnt_ch;
    logic [NUM_CH-1:0] gnt_vec;
    logic [CW-1:0]     arb_idx;

    // Match step for the granted channel
    logic [2:0]  gnt_sym;
    logic [3:0]  gnt_prog;
    logic [3:0]  prog_nxt;
    logic        sym_eq;
    logic        match_hit;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = CLEAR;
            CLEAR:   state_d = enable ? RUN : IDLE;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == RUN);
    assign dbg_state = state_q;

    // -----------------------------------------------------------------------
    // Round-robin arbiter: search starts one past the last granted channel.
    // Grants are suppressed in the RUN cycle where enable has dropped, so
    // nothing is accepted on the way back to IDLE.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_any = 1'b0;
        gnt_ch    = 3'd0;
        gnt_vec   = '0;
        arb_idx   = '0;
        if (state_q == RUN && enable) begin
            for (int i = 1; i <= NUM_CH; i++) begin
                arb_idx = CW'((int'(ptr_q) + i) % NUM_CH);
                if (!grant_any && bus.req_valid[arb_idx]) begin
                    grant_any        = 1'b1;
                    gnt_ch           = 3'(arb_idx);
                    gnt_vec[arb_idx] = 1'b1;
                end
            end
        end
    end

    // A grant is only issued to a valid channel, so grant_any is the
    // transfer strobe.
    assign bus.req_ready = gnt_vec;

    // -----------------------------------------------------------------------
    // Match step. On a mismatch only the first pattern symbol is considered
    // for restarting; longer prefix recovery is intentionally not done.
    // With len_q == 0 neither match branch can fire, so nothing ever hits.
    // -----------------------------------------------------------------------
    always_comb begin
        gnt_sym  = 3'd0;
        gnt_prog = 4'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt_vec[c]) begin
                gnt_sym  = bus.req_data[3*c +: 3];
                gnt_prog = prog_q[c];
            end
        end
    end

    always_comb begin
        sym_eq    = (gnt_sym == pat_q[gnt_prog[2:0]]);
        match_hit = 1'b0;
        prog_nxt  = 4'd0;
        if (sym_eq && (gnt_prog + 4'd1 == len_q)) begin
            match_hit = 1'b1;
            prog_nxt  = 4'd0;
        end else if (sym_eq && (gnt_prog + 4'd1 < len_q)) begin
            prog_nxt  = gnt_prog + 4'd1;
        end else if ((gnt_sym == pat_q[0]) && (len_q > 4'd1)) begin
            prog_nxt  = 4'd1;
        end else begin
            prog_nxt  = 4'd0;
        end
    end

    // -----------------------------------------------------------------------
    // Configuration, progress, pointer and hit registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 8; k++) begin
                pat_q[k] <= 3'd0;
            end
            len_q <= 4'd0;
        end else if (state_q == IDLE) begin
            if (cfg_sym_we && (int'(cfg_addr) < MAX_LEN)) begin
                pat_q[cfg_addr] <= cfg_sym;
            end
            if (cfg_len_we) begin
                len_q <= (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                prog_q[c] <= 4'd0;
            end
            ptr_q <= LAST_CH;
        end else if (state_q == CLEAR) begin
            for (int c = 0; c < NUM_CH; c++) begin
                prog_q[c] <= 4'd0;
            end
            ptr_q <= LAST_CH;
        end else if (grant_any) begin
            // Only the granted channel's progress moves.
            for (int c = 0; c < NUM_CH; c++) begin
                if (gnt_vec[c]) begin
                    prog_q[c] <= prog_nxt;
                end
            end
            ptr_q <= gnt_ch;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.hit_valid <= 1'b0;
            bus.hit_ch    <= 3'd0;
        end else begin
            bus.hit_valid <= grant_any && match_hit;
            if (grant_any && match_hit) begin
                bus.hit_ch <= gnt_ch;
            end
        end
    end

`ifdef SEQDET_RR_HITCNT_EN
    // -----------------------------------------------------------------------
    // Per-channel saturating hit counters. They update on the same edge
    // that raises hit_valid, so the count is visible with the pulse.
    // -----------------------------------------------------------------------
    logic [7:0] cnt_q [NUM_CH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= 8'd0;
            end
        end else if (state_q == CLEAR) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= 8'd0;
            end
        end else if (grant_any && match_hit) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (gnt_vec[c] && (cnt_q[c] != 8'hFF)) begin
                    cnt_q[c] <= cnt_q[c] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        cnt_value = 8'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cnt_sel == 3'(c)) begin
                cnt_value = cnt_q[c];
            end
        end
    end
`endif

endmodule
